// File: rtl/controlador_senha.sv
// rtl/controlador_senha.sv - keypad combination lock sequencing controller
module controlador_senha #(
    parameter int                     N_DIGITOS       = 6,
    parameter logic [4*N_DIGITOS-1:0] SENHA           = 24'h590281,
    parameter int                     TIMEOUT_CICLOS  = 1000,
    parameter int                     BLOQUEIO_CICLOS = 5000,
    parameter int                     MAX_TENTATIVAS  = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                insere,
    input  logic [4:1]                          numero,
    output logic                                LED,
    output logic                                aberto,
    output logic                                falha,
    output logic                                bloqueado,
    output logic [$clog2(N_DIGITOS):0]          indice,
    output logic [$clog2(MAX_TENTATIVAS+1)-1:0] tentativas,
    output logic                                digito_ok
);

    localparam int IW    = $clog2(N_DIGITOS) + 1;
    localparam int TW    = $clog2(MAX_TENTATIVAS + 1);
    localparam int CW_TO = $clog2(TIMEOUT_CICLOS);
    localparam int CW_BL = $clog2(BLOQUEIO_CICLOS);

    localparam logic [IW-1:0]    IDX_FIM  = IW'(N_DIGITOS);
    localparam logic [TW-1:0]    TENT_MAX = TW'(MAX_TENTATIVAS);
    localparam logic [CW_TO-1:0] TO_FIM   = CW_TO'(TIMEOUT_CICLOS - 1);
    localparam logic [CW_BL-1:0] BL_FIM   = CW_BL'(BLOQUEIO_CICLOS - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        ENTRADA,
        ABERTO,
        FALHA,
        BLOQUEIO
    } estado_t;

    estado_t          estado;
    logic             s1, s2, p;
    logic             ev;
    logic [3:0]       digito_esperado;
    logic             confere;
    logic [IW-1:0]    indice_prox;
    logic [CW_TO-1:0] cnt_timeout;
    logic [CW_BL-1:0] cnt_bloqueio;

    // Bring the raw button into the clock domain and keep the previous level for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            p  <= 1'b0;
        end else begin
            s1 <= insere;
            s2 <= s1;
            p  <= s2;
        end
    end

    assign ev = s2 & ~p;

    // Select the password nibble for the current position; digit 0 lives in the top nibble
    always_comb begin
        digito_esperado = 4'h0;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (indice == IW'(i)) begin
                digito_esperado = SENHA[4*(N_DIGITOS-1-i) +: 4];
            end
        end
    end

    // Non-decimal keys can never match, even if the password nibble happens to hold one
    assign confere     = (numero <= 4'd9) && (numero == digito_esperado);
    assign indice_prox = indice + 1'b1;

    // Main sequencing FSM; every status output is registered here
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado       <= OCIOSO;
            LED          <= 1'b0;
            aberto       <= 1'b0;
            falha        <= 1'b0;
            bloqueado    <= 1'b0;
            indice       <= '0;
            tentativas   <= '0;
            digito_ok    <= 1'b0;
            cnt_timeout  <= '0;
            cnt_bloqueio <= '0;
        end else begin
            digito_ok <= 1'b0;
            case (estado)
                OCIOSO, ENTRADA: begin
                    if (ev) begin
                        cnt_timeout <= '0;
                        if (confere) begin
                            indice    <= indice_prox;
                            digito_ok <= 1'b1;
                            if (indice_prox == IDX_FIM) begin
                                aberto <= 1'b1;
                                estado <= ABERTO;
                            end else begin
                                estado <= ENTRADA;
                            end
                        end else if (!LED) begin
                            LED <= 1'b1;
                        end else begin
                            falha      <= 1'b1;
                            tentativas <= tentativas + 1'b1;
                            estado     <= FALHA;
                        end
                    end else if (estado == ENTRADA) begin
                        // An event in the expiry cycle is handled above, so a late press still counts
                        if (cnt_timeout == TO_FIM) begin
                            estado      <= OCIOSO;
                            indice      <= '0;
                            LED         <= 1'b0;
                            cnt_timeout <= '0;
                        end else begin
                            cnt_timeout <= cnt_timeout + 1'b1;
                        end
                    end
                end
                ABERTO: begin
                    if (ev && numero == 4'hF) begin
                        estado     <= OCIOSO;
                        aberto     <= 1'b0;
                        LED        <= 1'b0;
                        indice     <= '0;
                        tentativas <= '0;
                    end
                end
                FALHA: begin
                    // tentativas already holds the incremented count on the first FALHA cycle
                    if (tentativas == TENT_MAX) begin
                        estado       <= BLOQUEIO;
                        falha        <= 1'b0;
                        bloqueado    <= 1'b1;
                        LED          <= 1'b0;
                        indice       <= '0;
                        cnt_bloqueio <= '0;
                    end else if (ev) begin
                        estado <= OCIOSO;
                        falha  <= 1'b0;
                        LED    <= 1'b0;
                        indice <= '0;
                    end
                end
                BLOQUEIO: begin
                    if (cnt_bloqueio == BL_FIM) begin
                        estado     <= OCIOSO;
                        bloqueado  <= 1'b0;
                        falha      <= 1'b0;
                        aberto     <= 1'b0;
                        LED        <= 1'b0;
                        indice     <= '0;
                        tentativas <= '0;
                    end else begin
                        cnt_bloqueio <= cnt_bloqueio + 1'b1;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_senha.sv
// tb/tb_controlador_senha.sv - randomized self-checking bench for controlador_senha
module tb_controlador_senha;

    localparam logic [23:0] SENHA = 24'h590281;

    logic       clk = 1'b0;
    logic       reset;
    logic       insere;
    logic [4:1] numero;
    logic       LED, aberto, falha, bloqueado, digito_ok;
    logic [3:0] indice;
    logic [1:0] tentativas;

    int n_tests = 0;
    int n_fail  = 0;
    int ok_total   = 0;
    int bloq_total = 0;

    // Event-level reference model of the lock
    bit m_aberto, m_falha, m_bloq, m_led;
    int m_idx, m_tent;

    controlador_senha dut (
        .clk        (clk),
        .reset      (reset),
        .insere     (insere),
        .numero     (numero),
        .LED        (LED),
        .aberto     (aberto),
        .falha      (falha),
        .bloqueado  (bloqueado),
        .indice     (indice),
        .tentativas (tentativas),
        .digito_ok  (digito_ok)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (digito_ok === 1'b1) ok_total++;
        if (bloqueado === 1'b1) bloq_total++;
    end

    function automatic logic [3:0] nib(input int idx);
        logic [23:0] s;
        s = SENHA >> (4 * (5 - idx));
        return s[3:0];
    endfunction

    function automatic logic [9:0] model_vec();
        return {m_aberto, m_falha, m_bloq, m_led, 4'(m_idx), 2'(m_tent)};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {aberto, falha, bloqueado, LED, indice, tentativas};
    endfunction

    task automatic model_reset();
        m_aberto = 0; m_falha = 0; m_bloq = 0; m_led = 0; m_idx = 0; m_tent = 0;
    endtask

    task automatic model_unlock();
        m_bloq = 0; m_tent = 0; m_led = 0; m_idx = 0; m_falha = 0; m_aberto = 0;
    endtask

    task automatic model_press(input logic [3:0] d, output int exp_ok);
        exp_ok = 0;
        if (m_bloq) begin
        end else if (m_falha) begin
            m_falha = 0; m_led = 0; m_idx = 0;
        end else if (m_aberto) begin
            if (d == 4'hF) begin
                m_aberto = 0; m_led = 0; m_idx = 0; m_tent = 0;
            end
        end else if (d <= 4'd9 && d == nib(m_idx)) begin
            m_idx++;
            exp_ok = 1;
            if (m_idx == 6) m_aberto = 1;
        end else if (!m_led) begin
            m_led = 1;
        end else begin
            m_tent++;
            if (m_tent == 3) begin
                m_bloq = 1; m_led = 0; m_idx = 0;
            end else begin
                m_falha = 1;
            end
        end
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        numero = d;
        insere = 1'b1;
        repeat (4) @(negedge clk);
        insere = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; insere = 1'b0; numero = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        n_tests++;
        if (obs_vec() !== model_vec()) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs_vec(), model_vec());
        end
        n_tests++;
        if (digito_ok !== 1'b0) begin
            n_fail++; $display("FAIL reset_digito_ok: got %b expected 0", digito_ok);
        end
    endtask

    task automatic test_open();
        logic [3:0] seq [7] = '{4'h5, 4'h9, 4'h0, 4'h2, 4'h8, 4'h1, 4'hF};
        int e, ok0;
        foreach (seq[i]) begin
            ok0 = ok_total;
            press(seq[i]);
            model_press(seq[i], e);
            n_tests++;
            if (obs_vec() !== model_vec()) begin
                n_fail++; $display("FAIL open step %0d: got %b expected %b", i, obs_vec(), model_vec());
            end
            n_tests++;
            if (ok_total - ok0 !== e) begin
                n_fail++; $display("FAIL open_pulse step %0d: got %0d expected %0d", i, ok_total - ok0, e);
            end
        end
    endtask

    task automatic test_led_tolerance();
        logic [3:0] seq [8] = '{4'h5, 4'h9, 4'h3, 4'h0, 4'h2, 4'h8, 4'h1, 4'hF};
        int e, ok0;
        foreach (seq[i]) begin
            ok0 = ok_total;
            press(seq[i]);
            model_press(seq[i], e);
            n_tests++;
            if (obs_vec() !== model_vec()) begin
                n_fail++; $display("FAIL led_tol step %0d: got %b expected %b", i, obs_vec(), model_vec());
            end
            n_tests++;
            if (ok_total - ok0 !== e) begin
                n_fail++; $display("FAIL led_tol_pulse step %0d: got %0d expected %0d", i, ok_total - ok0, e);
            end
        end
    endtask

    task automatic test_fail_ack();
        logic [3:0] seq [4] = '{4'h5, 4'h7, 4'h7, 4'h0};
        int e;
        foreach (seq[i]) begin
            press(seq[i]);
            model_press(seq[i], e);
            n_tests++;
            if (obs_vec() !== model_vec()) begin
                n_fail++; $display("FAIL fail_ack step %0d: got %b expected %b", i, obs_vec(), model_vec());
            end
        end
    endtask

    task automatic test_lockout();
        int e, ok0, b0, waited;
        logic [3:0] d;
        for (int i = 0; i < 10 && !m_bloq; i++) begin
            b0 = bloq_total;
            press(4'h7);
            model_press(4'h7, e);
            n_tests++;
            if (obs_vec() !== model_vec()) begin
                n_fail++; $display("FAIL lockout_entry step %0d: got %b expected %b", i, obs_vec(), model_vec());
            end
        end
        n_tests++;
        if (bloqueado !== 1'b1 || tentativas !== 2'd3) begin
            n_fail++; $display("FAIL lockout_active: got bloqueado=%b tentativas=%0d expected 1 and 3", bloqueado, tentativas);
        end
        for (int i = 0; i < 3; i++) begin
            d = (i == 0) ? 4'h5 : 4'($urandom_range(0, 15));
            ok0 = ok_total;
            press(d);
            model_press(d, e);
            n_tests++;
            if (obs_vec() !== model_vec() || ok_total != ok0) begin
                n_fail++; $display("FAIL lockout_ignore step %0d: got %b expected %b", i, obs_vec(), model_vec());
            end
        end
        waited = 0;
        while (bloqueado === 1'b1 && waited < 6000) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (bloqueado !== 1'b0) begin
            n_fail++; $display("FAIL lockout_release: got bloqueado=%b expected 0 within bound", bloqueado);
        end
        n_tests++;
        if (bloq_total - b0 != 5000) begin
            n_fail++; $display("FAIL lockout_length: got %0d cycles expected 5000", bloq_total - b0);
        end
        model_unlock();
        n_tests++;
        if (obs_vec() !== model_vec()) begin
            n_fail++; $display("FAIL lockout_exit: got %b expected %b", obs_vec(), model_vec());
        end
    endtask

    task automatic test_timeout();
        int e;
        press(4'h5);
        model_press(4'h5, e);
        press(4'h7);
        model_press(4'h7, e);
        n_tests++;
        if (obs_vec() !== model_vec()) begin
            n_fail++; $display("FAIL timeout_setup: got %b expected %b", obs_vec(), model_vec());
        end
        // Press 9 and land just after the edge that accepts it
        @(negedge clk);
        numero = 4'h9; insere = 1'b1;
        repeat (3) @(negedge clk);
        model_press(4'h9, e);
        n_tests++;
        if (digito_ok !== 1'b1 || obs_vec() !== model_vec()) begin
            n_fail++; $display("FAIL timeout_sync: got ok=%b %b expected ok=1 %b", digito_ok, obs_vec(), model_vec());
        end
        @(negedge clk);
        insere = 1'b0;
        repeat (996) @(negedge clk);
        // The next press is accepted on the 1000th idle edge, the same one the timeout would use
        numero = 4'h0; insere = 1'b1;
        repeat (3) @(negedge clk);
        model_press(4'h0, e);
        n_tests++;
        if (digito_ok !== 1'b1 || obs_vec() !== model_vec()) begin
            n_fail++; $display("FAIL timeout_late_press: got ok=%b %b expected ok=1 %b", digito_ok, obs_vec(), model_vec());
        end
        @(negedge clk);
        insere = 1'b0;
        repeat (998) @(negedge clk);
        n_tests++;
        if (obs_vec() !== model_vec()) begin
            n_fail++; $display("FAIL timeout_early: got %b expected %b", obs_vec(), model_vec());
        end
        @(negedge clk);
        m_idx = 0; m_led = 0;
        n_tests++;
        if (obs_vec() !== model_vec()) begin
            n_fail++; $display("FAIL timeout_expire: got %b expected %b", obs_vec(), model_vec());
        end
    endtask

    task automatic test_hold_and_reset();
        int e, ok0;
        ok0 = ok_total;
        @(negedge clk);
        numero = 4'h5; insere = 1'b1;
        repeat (50) @(negedge clk);
        insere = 1'b0;
        repeat (10) @(negedge clk);
        model_press(4'h5, e);
        n_tests++;
        if (ok_total - ok0 != 1 || obs_vec() !== model_vec()) begin
            n_fail++; $display("FAIL hold_single_event: got pulses=%0d %b expected 1 %b", ok_total - ok0, obs_vec(), model_vec());
        end
        press(4'h9); model_press(4'h9, e);
        press(4'h0); model_press(4'h0, e);
        n_tests++;
        if (obs_vec() !== model_vec()) begin
            n_fail++; $display("FAIL pre_reset: got %b expected %b", obs_vec(), model_vec());
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        n_tests++;
        if (obs_vec() !== model_vec() || digito_ok !== 1'b0) begin
            n_fail++; $display("FAIL mid_entry_reset: got %b expected %b", obs_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        int e, ok0, waited;
        logic [3:0] d;
        for (int i = 0; i < 40; i++) begin
            if (m_aberto)
                d = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            else if (m_falha)
                d = 4'($urandom_range(0, 15));
            else
                d = ($urandom_range(0, 3) != 0) ? nib(m_idx) : 4'($urandom_range(0, 15));
            ok0 = ok_total;
            press(d);
            model_press(d, e);
            n_tests++;
            if (obs_vec() !== model_vec() || ok_total - ok0 != e) begin
                n_fail++; $display("FAIL random step %0d digit %h: got %b pulses=%0d expected %b pulses=%0d",
                                   i, d, obs_vec(), ok_total - ok0, model_vec(), e);
            end
            if (m_bloq) begin
                waited = 0;
                while (bloqueado === 1'b1 && waited < 6000) begin
                    @(negedge clk);
                    waited++;
                end
                model_unlock();
                n_tests++;
                if (obs_vec() !== model_vec()) begin
                    n_fail++; $display("FAIL random_unlock step %0d: got %b expected %b", i, obs_vec(), model_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_led_tolerance();
        test_fail_ack();
        test_lockout();
        test_timeout();
        test_hold_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
